rf_out_stream_tx: RTL and testbench

- Output-direction companion to the vector register file's input FIFO path.
- The decode/writeback stage writes a vector to the reserved output register address OUT_ADDR. This block captures that write, buffers it in a synchronous FIFO, and transmits it lane by lane on a valid/ready stream to the external consumer.
- Lanes whose write enable is clear are skipped.
- Asserts wb_full so the writeback stage can stall.

---
 rtl/rf_out_stream_tx.sv | 121 ++++++++++++
 tb/tb_rf_out_stream_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_out_stream_tx.sv
// Captures writeback vectors addressed to OUT_ADDR in a FIFO and streams their enabled lanes out one beat at a time.
// Write-to-first-beat 2 cycles, one beat per cycle, one bubble between vectors; tx_ready low holds the beat, wb_full stalls writeback.
module rf_out_stream_tx #(
    parameter int WIDTH_ADDR   = 4,
    parameter int WIDTH_VECTOR = 8,
    parameter int N            = 32,
    parameter int WA_FIFO      = 3,
    parameter logic [WIDTH_ADDR-1:0] OUT_ADDR = '0,
    localparam int LW = (WIDTH_VECTOR > 1) ? $clog2(WIDTH_VECTOR) : 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [WIDTH_VECTOR-1:0]   wec,
    input  logic [WIDTH_ADDR-1:0]     addrc,
    input  logic [WIDTH_VECTOR*N-1:0] wdata_c,
    output logic                      wb_full,
    output logic                      wb_empty,
    output logic [WA_FIFO:0]          fifo_count,
    output logic                      overflow,
    output logic [N-1:0]              tx_data,
    output logic [LW-1:0]             tx_lane,
    output logic                      tx_last,
    output logic                      tx_valid,
    input  logic                      tx_ready
);

    localparam int DEPTH = 1 << WA_FIFO;
    localparam int EW    = WIDTH_VECTOR * (N + 1);
    localparam logic [WA_FIFO:0] FULL_CNT = (WA_FIFO + 1)'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state_q, state_d;
    logic [EW-1:0]             mem_q [DEPTH];
    logic [WA_FIFO-1:0]        wptr_q, rptr_q;
    logic [WA_FIFO:0]          count_q;
    logic                      overflow_q;
    logic [WIDTH_VECTOR-1:0]   mask_q, mask_d, mask_rest;
    logic [WIDTH_VECTOR*N-1:0] data_q, data_d;
    logic [EW-1:0]             head;
    logic [LW-1:0]             lane_sel;
    logic                      push_req, push, pop;

    assign wb_full    = (count_q == FULL_CNT);
    assign wb_empty   = (count_q == '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign push_req   = (addrc == OUT_ADDR) && (|wec);
    assign push       = push_req && !wb_full;
    assign head       = mem_q[rptr_q];
    // Remaining mask with its lowest set bit cleared; empty means the current lane is the last one.
    assign mask_rest  = mask_q & (mask_q - WIDTH_VECTOR'(1));

    always_comb begin
        lane_sel = '0;
        for (int i = WIDTH_VECTOR - 1; i >= 0; i--) begin
            if (mask_q[i]) lane_sel = LW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {wec, wdata_c};
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            mask_q     <= '0;
            data_q     <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + WA_FIFO'(1);
            if (pop)  rptr_q <= rptr_q + WA_FIFO'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (WA_FIFO + 1)'(1);
                2'b01:   count_q <= count_q - (WA_FIFO + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && wb_full) overflow_q <= 1'b1;
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        data_d   = data_q;
        pop      = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_lane  = '0;
        tx_data  = '0;
        case (state_q)
            IDLE: begin
                if (!wb_empty) begin
                    pop     = 1'b1;
                    mask_d  = head[EW-1 -: WIDTH_VECTOR];
                    data_d  = head[WIDTH_VECTOR*N-1:0];
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_lane  = lane_sel;
                tx_data  = data_q[int'(lane_sel)*N +: N];
                tx_last  = (mask_rest == '0);
                if (tx_ready) begin
                    mask_d = mask_rest;
                    if (tx_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rf_out_stream_tx.sv
// Directed bench for rf_out_stream_tx: capture, lane serialization, backpressure, overflow, filtering and reset.
module tb_rf_out_stream_tx;

    logic         clk = 1'b0;
    logic         rstn;
    logic [7:0]   wec;
    logic [3:0]   addrc;
    logic [255:0] wdata_c;
    logic         wb_full, wb_empty, overflow;
    logic [3:0]   fifo_count;
    logic [31:0]  tx_data;
    logic [2:0]   tx_lane;
    logic         tx_last, tx_valid, tx_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    int          got_lane [$];
    logic [31:0] got_data [$];
    bit          got_last [$];
    int          got_cyc  [$];
    bit          saw_valid;

    rf_out_stream_tx dut (
        .clk        (clk),
        .rstn       (rstn),
        .wec        (wec),
        .addrc      (addrc),
        .wdata_c    (wdata_c),
        .wb_full    (wb_full),
        .wb_empty   (wb_empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .tx_data    (tx_data),
        .tx_lane    (tx_lane),
        .tx_last    (tx_last),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mkdata(input logic [31:0] base);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = base + 32'(i);
        return d;
    endfunction

    // Called 1 time unit after a rising edge; returns 1 time unit after the sampling edge.
    task automatic write_vec(input logic [3:0] a, input logic [7:0] m, input logic [255:0] d);
        addrc   = a;
        wec     = m;
        wdata_c = d;
        @(posedge clk);
        #1;
        addrc = '0;
        wec   = '0;
    endtask

    task automatic collect(input int cycles);
        got_lane.delete();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        saw_valid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (tx_valid) saw_valid = 1'b1;
            if (tx_valid && tx_ready) begin
                got_lane.push_back(int'(tx_lane));
                got_data.push_back(tx_data);
                got_last.push_back(tx_last);
                got_cyc.push_back(c);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %0b expected 0", tx_valid); end
        n_cmp++; if (tx_last !== 1'b0) begin n_fail++; $display("FAIL rst_tx_last: got %0b expected 0", tx_last); end
        n_cmp++; if (tx_data !== 32'h0) begin n_fail++; $display("FAIL rst_tx_data: got %0h expected 0", tx_data); end
        n_cmp++; if (tx_lane !== 3'd0) begin n_fail++; $display("FAIL rst_tx_lane: got %0d expected 0", tx_lane); end
        n_cmp++; if (wb_full !== 1'b0) begin n_fail++; $display("FAIL rst_wb_full: got %0b expected 0", wb_full); end
        n_cmp++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL rst_wb_empty: got %0b expected 1", wb_empty); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", overflow); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        tx_ready = 1'b1;
        write_vec(4'd0, 8'hFF, mkdata(32'h1000_0000));
        n_cmp++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count_after_push: got %0d expected 1", fifo_count); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %0b expected 0", tx_valid); end
        collect(12);
        n_cmp++; if (got_lane.size() != 8) begin n_fail++; $display("FAIL single_beats: got %0d expected 8", got_lane.size()); end
        if (got_cyc.size() > 0) begin
            n_cmp++; if (got_cyc[0] != 1) begin n_fail++; $display("FAIL single_latency: got cycle %0d expected 1", got_cyc[0]); end
        end
        for (int i = 0; i < got_lane.size() && i < 8; i++) begin
            n_cmp++; if (got_lane[i] != i) begin n_fail++; $display("FAIL single_lane[%0d]: got %0d expected %0d", i, got_lane[i], i); end
            n_cmp++; if (got_data[i] !== 32'h1000_0000 + 32'(i)) begin n_fail++; $display("FAIL single_data[%0d]: got %0h expected %0h", i, got_data[i], 32'h1000_0000 + 32'(i)); end
            n_cmp++; if (got_last[i] != (i == 7)) begin n_fail++; $display("FAIL single_last[%0d]: got %0b expected %0b", i, got_last[i], (i == 7)); end
        end
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL single_count_end: got %0d expected 0", fifo_count); end
        n_cmp++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_end: got %0b expected 1", wb_empty); end
    endtask

    task automatic test_sparse();
        tx_ready = 1'b1;
        write_vec(4'd0, 8'h81, mkdata(32'hA000_0000));
        collect(8);
        n_cmp++; if (got_lane.size() != 2) begin n_fail++; $display("FAIL sparse_beats: got %0d expected 2", got_lane.size()); end
        if (got_lane.size() >= 2) begin
            n_cmp++; if (got_lane[0] != 0) begin n_fail++; $display("FAIL sparse_lane0: got %0d expected 0", got_lane[0]); end
            n_cmp++; if (got_data[0] !== 32'hA000_0000) begin n_fail++; $display("FAIL sparse_data0: got %0h expected a0000000", got_data[0]); end
            n_cmp++; if (got_last[0] != 1'b0) begin n_fail++; $display("FAIL sparse_last0: got %0b expected 0", got_last[0]); end
            n_cmp++; if (got_lane[1] != 7) begin n_fail++; $display("FAIL sparse_lane1: got %0d expected 7", got_lane[1]); end
            n_cmp++; if (got_data[1] !== 32'hA000_0007) begin n_fail++; $display("FAIL sparse_data1: got %0h expected a0000007", got_data[1]); end
            n_cmp++; if (got_last[1] != 1'b1) begin n_fail++; $display("FAIL sparse_last1: got %0b expected 1", got_last[1]); end
        end
    endtask

    task automatic test_backpressure();
        tx_ready = 1'b0;
        write_vec(4'd0, 8'h0F, mkdata(32'hB000_0000));
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %0b expected 1", k, tx_valid); end
            n_cmp++; if (tx_lane !== 3'd0) begin n_fail++; $display("FAIL bp_lane[%0d]: got %0d expected 0", k, tx_lane); end
            n_cmp++; if (tx_data !== 32'hB000_0000) begin n_fail++; $display("FAIL bp_data[%0d]: got %0h expected b0000000", k, tx_data); end
            n_cmp++; if (tx_last !== 1'b0) begin n_fail++; $display("FAIL bp_last[%0d]: got %0b expected 0", k, tx_last); end
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        collect(8);
        n_cmp++; if (got_lane.size() != 4) begin n_fail++; $display("FAIL bp_beats: got %0d expected 4", got_lane.size()); end
        for (int i = 0; i < got_lane.size() && i < 4; i++) begin
            n_cmp++; if (got_lane[i] != i) begin n_fail++; $display("FAIL bp_lane_out[%0d]: got %0d expected %0d", i, got_lane[i], i); end
            n_cmp++; if (got_data[i] !== 32'hB000_0000 + 32'(i)) begin n_fail++; $display("FAIL bp_data_out[%0d]: got %0h expected %0h", i, got_data[i], 32'hB000_0000 + 32'(i)); end
            n_cmp++; if (got_last[i] != (i == 3)) begin n_fail++; $display("FAIL bp_last_out[%0d]: got %0b expected %0b", i, got_last[i], (i == 3)); end
        end
    endtask

    task automatic test_fill_overflow();
        logic [255:0] d;
        tx_ready = 1'b0;
        for (int v = 0; v < 10; v++) begin
            d = '0;
            d[31:0]  = 32'h0000_C000 + 32'(v);
            d[63:32] = 32'h0000_D000 + 32'(v);
            write_vec(4'd0, 8'h03, d);
        end
        n_cmp++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL fill_count: got %0d expected 8", fifo_count); end
        n_cmp++; if (wb_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b expected 1", wb_full); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow: got %0b expected 1", overflow); end
        n_cmp++; if (tx_data !== 32'h0000_C000) begin n_fail++; $display("FAIL fill_head_data: got %0h expected c000", tx_data); end
        tx_ready = 1'b1;
        collect(40);
        n_cmp++; if (got_lane.size() != 18) begin n_fail++; $display("FAIL fill_beats: got %0d expected 18", got_lane.size()); end
        for (int j = 0; j < got_lane.size() && j < 18; j++) begin
            n_cmp++;
            if (got_data[j] !== ((j % 2 == 0) ? 32'h0000_C000 : 32'h0000_D000) + 32'(j / 2)) begin
                n_fail++;
                $display("FAIL fill_data[%0d]: got %0h expected %0h", j, got_data[j], ((j % 2 == 0) ? 32'h0000_C000 : 32'h0000_D000) + 32'(j / 2));
            end
            n_cmp++; if (got_last[j] != (j % 2 == 1)) begin n_fail++; $display("FAIL fill_last[%0d]: got %0b expected %0b", j, got_last[j], (j % 2 == 1)); end
        end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow_sticky: got %0b expected 1", overflow); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL fill_count_end: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_nontarget();
        tx_ready = 1'b1;
        write_vec(4'd3, 8'hFF, mkdata(32'hE000_0000));
        n_cmp++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL nt_addr_empty: got %0b expected 1", wb_empty); end
        write_vec(4'd0, 8'h00, mkdata(32'hF000_0000));
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL nt_wec_count: got %0d expected 0", fifo_count); end
        collect(6);
        n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL nt_valid: got %0b expected 0", saw_valid); end
        n_cmp++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL nt_empty_end: got %0b expected 1", wb_empty); end
    endtask

    task automatic test_reset_midburst();
        tx_ready = 1'b1;
        write_vec(4'd0, 8'hFF, mkdata(32'h5000_0000));
        write_vec(4'd0, 8'hFF, mkdata(32'h6000_0000));
        write_vec(4'd0, 8'hFF, mkdata(32'h7000_0000));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_cmp++; if (tx_lane !== 3'd3) begin n_fail++; $display("FAIL mr_lane_before: got %0d expected 3", tx_lane); end
        n_cmp++; if (tx_data !== 32'h5000_0003) begin n_fail++; $display("FAIL mr_data_before: got %0h expected 50000003", tx_data); end
        n_cmp++; if (fifo_count !== 4'd2) begin n_fail++; $display("FAIL mr_count_before: got %0d expected 2", fifo_count); end
        #2;
        rstn = 1'b1;
        #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL mr_valid_async: got %0b expected 0", tx_valid); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL mr_count_async: got %0d expected 0", fifo_count); end
        n_cmp++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL mr_empty_async: got %0b expected 1", wb_empty); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mr_overflow_cleared: got %0b expected 0", overflow); end
        @(posedge clk);
        #1;
        rstn = 1'b0;
        collect(8);
        n_cmp++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL mr_no_tx_after_reset: got %0b expected 0", saw_valid); end
        write_vec(4'd0, 8'h10, mkdata(32'h7700_0000));
        collect(6);
        n_cmp++; if (got_lane.size() != 1) begin n_fail++; $display("FAIL mr_new_beats: got %0d expected 1", got_lane.size()); end
        if (got_lane.size() == 1) begin
            n_cmp++; if (got_lane[0] != 4) begin n_fail++; $display("FAIL mr_new_lane: got %0d expected 4", got_lane[0]); end
            n_cmp++; if (got_data[0] !== 32'h7700_0004) begin n_fail++; $display("FAIL mr_new_data: got %0h expected 77000004", got_data[0]); end
            n_cmp++; if (got_last[0] != 1'b1) begin n_fail++; $display("FAIL mr_new_last: got %0b expected 1", got_last[0]); end
        end
    endtask

    initial begin
        rstn     = 1'b1;
        tx_ready = 1'b0;
        wec      = '0;
        addrc    = '0;
        wdata_c  = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        test_reset();
        test_single();
        test_sparse();
        test_backpressure();
        test_fill_overflow();
        test_nontarget();
        test_reset_midburst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
